// File: rtl/bridge_utils_pkg.sv
// Shared types and AXI constants for the write-burst bridge.
// Package name: bridge_utils.
package bridge_utils;

    localparam int unsigned INFO_ADDR_WIDTH = 64;
    localparam int unsigned INFO_ID_WIDTH   = 16;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_NOP           = 2'd0,
        R_GET_ADDR_DATA = 2'd1,
        R_GET_RESP      = 2'd2
    } rd_cmd_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_BUSY   = 2'd1,
        R_SWITCH = 2'd2
    } rd_info_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_AW        = 3'd1,
        S_W         = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_B         = 3'd4
    } wr_state_t;

    // Captured AW channel, sized for the widest configuration.
    typedef struct packed {
        logic [INFO_ID_WIDTH-1:0]   id;
        logic [INFO_ADDR_WIDTH-1:0] addr;
        logic [3:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } addr_info_t;

    // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [3:0] len);
        return (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address stepping (FIXED / INCR / WRAP). Loads the start
// address, then advances one beat per step pulse.
module axi_burst_addr_gen
    import bridge_utils::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] start,
    input  logic [2:0]            size,
    input  logic [3:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Illegal burst shapes fall back to INCR stepping; the error is flagged upstream.
    always_comb begin
        incr      = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'({1'b0, len}) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        next_addr = addr + incr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && !burst_illegal(burst, len)) begin
            next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= start;
        end else if (step) begin
            addr <= next_addr;
        end
    end

endmodule

// File: rtl/axi_wr_burst_reader.sv
// AXI3 write-burst slave front end: captures AW, streams W beats straight into
// a FIFO and returns B once the engine supplies a response.
// Optional: define AXI_WID_CHECK_EN to flag beats whose wid differs from awid.
module axi_wr_burst_reader
    import bridge_utils::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  rd_cmd_t                 rd_cmd,
    output rd_info_t                rd_info,
    input  logic [1:0]              resp_in,
    input  logic                    fifo_full,
    output logic                    fifo_write,
    output logic [DATA_WIDTH-1:0]   fifo_data,
    output logic [DATA_WIDTH/8-1:0] fifo_strb,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output addr_info_t              addr_info
);

    localparam int unsigned CNT_WIDTH = 5;

    wr_state_t             state;
    wr_state_t             state_nxt;
    logic [ID_WIDTH-1:0]   cap_id;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [3:0]            cap_len;
    logic [2:0]            cap_size;
    logic [1:0]            cap_burst;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  err;
    logic                  aw_hs;
    logic                  beat_acc;
    logic                  last_beat;
    logic                  burst_end;
    logic                  wid_err;

    assign aw_hs     = awready && awvalid;
    assign beat_acc  = fifo_write;
    assign last_beat = (beat_cnt == CNT_WIDTH'(cap_len));
    assign burst_end = wlast || last_beat;

`ifdef AXI_WID_CHECK_EN
    assign wid_err = (wid != cap_id);
`else
    logic unused_wid;
    assign unused_wid = ^wid;
    assign wid_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (rd_cmd == R_GET_ADDR_DATA) state_nxt = S_AW;
            S_AW:        if (awvalid) state_nxt = S_W;
            S_W:         if (beat_acc && burst_end) state_nxt = S_WAIT_RESP;
            S_WAIT_RESP: if (rd_cmd == R_GET_RESP) state_nxt = S_B;
            S_B:         if (bready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // W beats pass through to the FIFO in the same cycle they are accepted.
    always_comb begin
        awready    = 1'b0;
        wready     = 1'b0;
        fifo_write = 1'b0;
        bvalid     = 1'b0;
        rd_info    = R_BUSY;
        fifo_data  = wdata;
        fifo_strb  = wstrb;
        case (state)
            S_IDLE:      rd_info = R_IDLE;
            S_AW:        awready = 1'b1;
            S_W: begin
                wready     = !fifo_full;
                fifo_write = wvalid && !fifo_full;
            end
            S_WAIT_RESP: rd_info = R_SWITCH;
            S_B:         bvalid  = 1'b1;
            default:     rd_info = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_id    <= '0;
            cap_addr  <= '0;
            cap_len   <= '0;
            cap_size  <= '0;
            cap_burst <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
        end else begin
            if (aw_hs) begin
                cap_id    <= awid;
                cap_addr  <= awaddr;
                cap_len   <= awlen;
                cap_size  <= awsize;
                cap_burst <= awburst;
                beat_cnt  <= '0;
                err       <= burst_illegal(awburst, awlen);
            end
            // wlast must coincide exactly with the final beat of awlen+1.
            if (beat_acc) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                err      <= err || (wlast != last_beat) || wid_err;
            end
            if ((state == S_WAIT_RESP) && (rd_cmd == R_GET_RESP)) begin
                bid   <= cap_id;
                bresp <= err ? RESP_SLVERR : resp_in;
            end
        end
    end

    always_comb begin
        addr_info       = '0;
        addr_info.id    = INFO_ID_WIDTH'(cap_id);
        addr_info.addr  = INFO_ADDR_WIDTH'(cap_addr);
        addr_info.len   = cap_len;
        addr_info.size  = cap_size;
        addr_info.burst = cap_burst;
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (aw_hs),
        .step  (beat_acc),
        .start (awaddr),
        .size  (cap_size),
        .len   (cap_len),
        .burst (cap_burst),
        .addr  (beat_addr)
    );

endmodule

// File: tb/tb_axi_wr_burst_reader.sv
// Randomised bench for axi_wr_burst_reader against a burst-level reference model.
module tb_axi_wr_burst_reader;
    import bridge_utils::*;

    localparam int NO_ABORT   = -1;
    localparam int ABORT_IN_B = -2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    rd_cmd_t     rd_cmd = R_NOP;
    rd_info_t    rd_info;
    logic [1:0]  resp_in = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_strb;
    logic [31:0] beat_addr;
    addr_info_t  addr_info;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;

    axi_wr_burst_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_cmd(rd_cmd), .rd_info(rd_info), .resp_in(resp_in), .fifo_full(fifo_full),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_strb(fifo_strb),
        .beat_addr(beat_addr), .addr_info(addr_info)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fifo_write) wr_count++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address of beat i, computed directly from the burst's byte window.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input int size, input logic [1:0] burst, input int i);
        longint bytes = longint'(1) << size;
        longint total = longint'(len + 1) * bytes;
        longint base;
        case (burst)
            2'b00:   return a;
            2'b01:   return 32'(longint'(a) + longint'(i) * bytes);
            default: begin
                base = longint'(a) - (longint'(a) % total);
                return 32'(base + ((longint'(a) - base) + longint'(i) * bytes) % total);
            end
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".awready"},    64'(awready), 64'd0);
        check_eq({tag, ".wready"},     64'(wready), 64'd0);
        check_eq({tag, ".bvalid"},     64'(bvalid), 64'd0);
        check_eq({tag, ".fifo_write"}, 64'(fifo_write), 64'd0);
        check_eq({tag, ".bid"},        64'(bid), 64'd0);
        check_eq({tag, ".bresp"},      64'(bresp), 64'd0);
        check_eq({tag, ".beat_addr"},  64'(beat_addr), 64'd0);
        check_eq({tag, ".addr_info"},  64'(addr_info.addr) | 64'(addr_info.len), 64'd0);
        check_eq({tag, ".rd_info"},    64'(rd_info), 64'(R_IDLE));
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                             input int bad_wid_beat, input logic [1:0] resp, input int stall_at,
                             input bit rand_ff, input int abort_at);
        logic [31:0] exp_addr[$];
        int    exp_beats;
        bit    exp_err;
        bit    addr_chk;
        int    beat = 0;
        int    cyc = 0;
        int    stalled = 0;
        int    wc0;
        int    hold;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  exp_resp;

        addr_chk  = !((burst == 2'b11) || (burst == 2'b10 && !(int'(len) inside {1, 3, 7, 15})));
        exp_err   = !addr_chk || (wlast_at != int'(len));
        exp_beats = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
`ifdef AXI_WID_CHECK_EN
        if (bad_wid_beat >= 0 && bad_wid_beat < exp_beats) exp_err = 1'b1;
`endif
        for (int i = 0; i < exp_beats; i++) exp_addr.push_back(model_addr(addr, int'(len), int'(size), burst, i));
        exp_resp = exp_err ? 2'b10 : resp;

        @(negedge clk);
        rd_cmd = R_GET_ADDR_DATA;
        @(negedge clk);
        rd_cmd = R_NOP;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        check_eq("aw.awready", 64'(awready), 64'd1);
        check_eq("aw.rd_info", 64'(rd_info), 64'(R_BUSY));

        wc0 = wr_count;
        while (beat < exp_beats && cyc < 200) begin
            @(negedge clk);
            awvalid = 1'b0;
            if (beat == abort_at) begin
                rst_n = 1'b0; wvalid = 1'b0; wlast = 1'b0; fifo_full = 1'b0;
                #1;
                check_idle_outputs("abort_w");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (stall_at == beat && stalled < 3) begin
                fifo_full = 1'b1;
                stalled++;
            end else begin
                fifo_full = rand_ff ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            wvalid = rand_ff ? ($urandom_range(0, 4) != 0) : 1'b1;
            d = $urandom; s = 4'($urandom);
            wdata = d; wstrb = s;
            wlast = (beat == wlast_at);
            wid = (beat == bad_wid_beat) ? (id ^ 4'h6) : id;
            #1;
            if (cyc == 0) begin
                check_eq("aw.info_addr", 64'(addr_info.addr), 64'(addr));
                check_eq("aw.info_len",  64'(addr_info.len), 64'(len));
            end
            check_eq("w.wready", 64'(wready), 64'(!fifo_full));
            if (addr_chk) check_eq("w.beat_addr", 64'(beat_addr), 64'(exp_addr[beat]));
            if (wvalid && !fifo_full) begin
                check_eq("w.fifo_write", 64'(fifo_write), 64'd1);
                check_eq("w.fifo_data",  64'(fifo_data), 64'(d));
                check_eq("w.fifo_strb",  64'(fifo_strb), 64'(s));
                beat++;
            end else begin
                check_eq("w.no_write", 64'(fifo_write), 64'd0);
            end
            cyc++;
        end
        if (beat < exp_beats) check_eq("w.timeout", 64'(beat), 64'(exp_beats));

        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; fifo_full = 1'b0;
        rd_cmd = R_GET_ADDR_DATA;
        #1;
        check_eq("wr.rd_info", 64'(rd_info), 64'(R_SWITCH));
        check_eq("wr.fifo_write", 64'(fifo_write), 64'd0);
        check_eq("wr.beats", 64'(wr_count - wc0), 64'(exp_beats));
        @(negedge clk);
        #1;
        check_eq("wr.ignore_cmd", 64'(rd_info), 64'(R_SWITCH));
        rd_cmd = R_GET_RESP; resp_in = resp;
        @(negedge clk);
        rd_cmd = R_NOP; resp_in = ~resp;
        #1;
        check_eq("b.bvalid", 64'(bvalid), 64'd1);
        check_eq("b.bid", 64'(bid), 64'(id));
        check_eq("b.bresp", 64'(bresp), 64'(exp_resp));
        check_eq("b.rd_info", 64'(rd_info), 64'(R_BUSY));
        if (abort_at == ABORT_IN_B) begin
            rst_n = 1'b0;
            #1;
            check_idle_outputs("abort_b");
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check_eq("b.hold_bvalid", 64'(bvalid), 64'd1);
            check_eq("b.hold_bresp", 64'(bresp), 64'(exp_resp));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        check_eq("b.done_bvalid", 64'(bvalid), 64'd0);
        check_eq("b.done_rd_info", 64'(rd_info), 64'(R_IDLE));
    endtask

    initial begin
        logic [3:0]  r_id;
        logic [31:0] r_addr;
        logic [3:0]  r_len;
        logic [2:0]  r_size;
        logic [1:0]  r_burst;
        int          r_wlast;
        int          r_bad;

        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // A response request in IDLE must be ignored.
        @(negedge clk);
        rd_cmd = R_GET_RESP;
        @(negedge clk);
        rd_cmd = R_NOP;
        #1;
        check_eq("idle.ignore_cmd", 64'(rd_info), 64'(R_IDLE));

        run_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 3, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd2, 32'h108, 4'd3, 3'd2, 2'b10, 3, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd1, 32'h200, 4'd3, 3'd2, 2'b01, 1, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd7, 32'h300, 4'd3, 3'd2, 2'b01, 3, -1, 2'b01, 2, 1'b0, NO_ABORT);
        run_burst(4'd4, 32'h400, 4'd3, 3'd2, 2'b01, 3, -1, 2'b00, -1, 1'b0, 1);
        run_burst(4'd4, 32'h400, 4'd3, 3'd2, 2'b01, 3, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd3, 32'h500, 4'd3, 3'd2, 2'b01, 3, 1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd6, 32'h600, 4'd2, 3'd2, 2'b00, 2, -1, 2'b01, -1, 1'b0, NO_ABORT);
        run_burst(4'd8, 32'h700, 4'd2, 3'd2, 2'b11, 2, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'd9, 32'h800, 4'd2, 3'd2, 2'b10, 2, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'hA, 32'h900, 4'd2, 3'd2, 2'b01, 20, -1, 2'b00, -1, 1'b0, NO_ABORT);
        run_burst(4'hB, 32'hA00, 4'd1, 3'd2, 2'b01, 1, -1, 2'b00, -1, 1'b0, ABORT_IN_B);
        run_burst(4'hC, 32'h3C, 4'd15, 3'd2, 2'b10, 15, -1, 2'b11, -1, 1'b1, NO_ABORT);

        for (int n = 0; n < 40; n++) begin
            r_id    = 4'($urandom);
            r_len   = 4'($urandom);
            r_size  = 3'($urandom_range(0, 2));
            r_burst = 2'($urandom_range(0, 3));
            r_addr  = $urandom & ~((32'd1 << r_size) - 32'd1);
            r_wlast = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : int'(r_len);
            r_bad   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_burst(r_id, r_addr, r_len, r_size, r_burst, r_wlast, r_bad,
                      2'($urandom), -1, 1'b1, NO_ABORT);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_reader.md
AXI_WR_BURST_READER -- requirements
Module: axi_wr_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width; strobe width DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have AW ports: awid in ID_WIDTH; awaddr in ADDR_WIDTH; awlen in 4; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-006 SHALL have W ports: wid in ID_WIDTH; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-007 SHALL have B ports: bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-008 SHALL have engine ports: rd_cmd in rd_cmd_t (R_NOP/R_GET_ADDR_DATA/R_GET_RESP); rd_info out rd_info_t (R_IDLE/R_BUSY/R_SWITCH); resp_in in 2 engine response; fifo_full in 1.
REQ-009 SHALL have FIFO ports: fifo_write out 1; fifo_data out DATA_WIDTH; fifo_strb out DATA_WIDTH/8; beat_addr out ADDR_WIDTH per-beat address; addr_info out addr_info_t captured AW.

Function
REQ-010 SHALL implement states IDLE, AW, W, WAIT_RESP, B; IDLE->AW on rd_cmd==R_GET_ADDR_DATA.
REQ-011 AW: awready=1; on awvalid capture awid/addr/len/size/burst, clear beat counter and err flag, go W next cycle.
REQ-012 W: wready = !fifo_full; beat accepted when wvalid&&wready; fifo_write=1 same cycle, fifo_data=wdata, fifo_strb=wstrb, combinational (zero latency).
REQ-013 beat_addr SHALL equal captured awaddr on beat 0 and advance per accepted beat: FIXED unchanged; INCR +(1<<size); WRAP increments within aligned (len+1)<<size window, wrapping to its base.
REQ-014 Burst SHALL end on accepted beat with wlast=1 or beat count == awlen+1, whichever first; then WAIT_RESP.
REQ-015 wlast=1 before beat awlen+1, or wlast=0 on beat awlen+1, SHALL set sticky err flag.
REQ-016 awburst==2'b11 (reserved) or WRAP with len not in {1,3,7,15} SHALL set err flag; beats still accepted.
REQ-017 WAIT_RESP: rd_info=R_SWITCH; on rd_cmd==R_GET_RESP register bresp = err ? 2'b10 (SLVERR) : resp_in, go B.
REQ-018 B: bvalid=1, bid=captured awid, bresp stable until bready; on bready go IDLE.
REQ-019 rd_info SHALL be R_IDLE in IDLE, R_BUSY in AW/W/B, R_SWITCH in WAIT_RESP.
REQ-020 fifo_full asserted mid-burst SHALL stall with no beat lost or duplicated; beat_addr held.
REQ-021 rd_cmd values other than those expected in the current state SHALL be ignored.

Reset
REQ-022 On rst_n low: state IDLE; awready, wready, bvalid, fifo_write 0; bid, bresp, beat_addr, addr_info, counters, err flag 0.
REQ-023 Reset mid-burst or during B SHALL abandon transfer; bvalid drops asynchronously, no response issued.

Configuration
REQ-024 Macro AXI_WID_CHECK_EN defined: accepted beat with wid != captured awid SHALL set err flag (beat still written).
REQ-025 AXI_WID_CHECK_EN undefined: wid SHALL be ignored, no logic generated for it.

Structure
REQ-026 rd_cmd_t, rd_info_t, addr_info_t, AXI burst encodings (FIXED/INCR/WRAP) and response constants (OKAY 2'b00, SLVERR 2'b10) SHALL live in package bridge_utils.
REQ-027 Per-beat address stepping SHALL be sub-module axi_burst_addr_gen (start, size, len, burst, step -> addr).

Verification
REQ-028 INCR awaddr=0x100, len=3, size=2, 4 beats, wlast on beat 4, resp_in=00 -> beat_addr 0x100,0x104,0x108,0x10C; bresp=00, bid=awid.
REQ-029 WRAP awaddr=0x108, len=3, size=2 -> beat_addr 0x108,0x10C,0x100,0x104.
REQ-030 INCR len=3 with wlast on beat 2 -> 2 fifo_writes, WAIT_RESP, bresp=10 regardless of resp_in.
REQ-031 fifo_full high 3 cycles mid-burst -> wready=0, fifo_write=0 those cycles; total fifo_writes = len+1, data order preserved.
REQ-032 rst_n low during W beat 2 of 4 -> IDLE, all outputs 0; next full burst completes with bresp=00.
REQ-033 AXI_WID_CHECK_EN defined, awid=3, wid=5 on one beat -> bresp=10; undefined -> bresp=resp_in.
